rnn_mem_arbiter: RTL and testbench

- Shares the single RNN memory port (mce/msel/maddr/mdata_w/mdata_r) between two requesters: requester 0 is the RNN compute core and requester 1 is the host weight/state loader.
- Performs per-cycle arbitration: round-robin, plus a lock for bursts and a bounded burst length for fairness.
- Registers the memory command and routes read data back to the requester that issued the read.
- Sits between the requesters and the memory macro; owns the memory timing.

---
 rtl/rnn_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_rnn_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rnn_mem_arbiter.sv
// rtl/rnn_mem_arbiter.sv - two-requester arbiter for the single RNN memory port
//
// Shares one memory port between requester 0 (RNN compute core) and
// requester 1 (host weight/state loader). Round-robin arbitration, with a
// lock that keeps a burst on the same owner for a bounded number of
// contested grants. The memory command is registered; read data is routed
// back to the issuing requester through a 2-stage tag pipeline.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   rN_req / rN_lock           request, hold grant for following cycles
//   rN_sel / rN_addr / rN_wdata  msel code, address, write data
//   rN_gnt                     combinational grant (accepted on req&gnt)
//   rN_rvalid / rN_rdata       read return for requester N
//   mce / msel / maddr / mdata_w  registered memory command
//   mdata_r                    memory read data, valid the cycle after mce
module rnn_mem_arbiter #(
  parameter int                AW        = 17,
  parameter int                DW        = 20,
  parameter int                SW        = 3,
  parameter logic [SW-1:0]     WR_SEL    = 3'b101,
  parameter logic [SW-1:0]     IDLE_SEL  = 3'b100,
  parameter int                MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r1_req,
  input  logic          r0_lock,
  input  logic          r1_lock,
  input  logic [SW-1:0] r0_sel,
  input  logic [SW-1:0] r1_sel,
  input  logic [AW-1:0] r0_addr,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic [DW-1:0] r1_wdata,
  output logic          r0_gnt,
  output logic          r1_gnt,
  output logic          r0_rvalid,
  output logic          r1_rvalid,
  output logic [DW-1:0] r0_rdata,
  output logic [DW-1:0] r1_rdata,
  output logic          mce,
  output logic [SW-1:0] msel,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mdata_w,
  input  logic [DW-1:0] mdata_r
);

  localparam int            CW          = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_BURST - 1);
  localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};

  logic          last;         // winner of the most recent accepted request
  logic          prev_acc;     // a request was accepted at the previous edge
  logic          lock_active;  // previous accepted request carried lock
  logic [CW-1:0] burst_cnt;

  logic          t1_valid, t1_id;
  logic          t2_valid, t2_id;

  logic          win;
  logic          accept;
  logic          w_lock;
  logic          other_req;
  logic [SW-1:0] w_sel;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  always_comb begin
    win = 1'b0;
    if (r0_req && r1_req) begin
      // The locked owner keeps the port until its contested streak is used up.
      if (lock_active && (burst_cnt < BURST_LIMIT)) begin
        win = last;
      end else begin
        win = ~last;
      end
    end else if (r1_req) begin
      win = 1'b1;
    end

    r0_gnt    = r0_req & ~win;
    r1_gnt    = r1_req & win;
    // Grants raised while reset is sampled are not accepted.
    accept    = (r0_req | r1_req) & ~reset;
    w_lock    = win ? r1_lock  : r0_lock;
    other_req = win ? r0_req   : r1_req;
    w_sel     = win ? r1_sel   : r0_sel;
    w_addr    = win ? r1_addr  : r0_addr;
    w_wdata   = win ? r1_wdata : r0_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mce         <= 1'b0;
      msel        <= IDLE_SEL;
      maddr       <= '0;
      mdata_w     <= '0;
      last        <= 1'b1;
      prev_acc    <= 1'b0;
      lock_active <= 1'b0;
      burst_cnt   <= '0;
      t1_valid    <= 1'b0;
      t1_id       <= 1'b0;
      t2_valid    <= 1'b0;
      t2_id       <= 1'b0;
    end else begin
      mce         <= accept;
      msel        <= accept ? w_sel : IDLE_SEL;
      if (accept) begin
        maddr   <= w_addr;
        mdata_w <= w_wdata;
        last    <= win;
      end
      prev_acc    <= accept;
      lock_active <= accept & w_lock;

      // Streak of back-to-back grants to the same winner under competition;
      // an uncontested grant restarts the streak at zero.
      if (accept && other_req && prev_acc && (win == last)) begin
        if (burst_cnt != CNT_MAX) begin
          burst_cnt <= burst_cnt + 1'b1;
        end
      end else begin
        burst_cnt <= '0;
      end

      t1_valid <= accept && (w_sel != WR_SEL);
      t1_id    <= win;
      t2_valid <= t1_valid;
      t2_id    <= t1_id;
    end
  end

  assign r0_rvalid = t2_valid & ~t2_id;
  assign r1_rvalid = t2_valid & t2_id;
  assign r0_rdata  = mdata_r;
  assign r1_rdata  = mdata_r;

endmodule

// File: tb/tb_rnn_mem_arbiter.sv
// tb/tb_rnn_mem_arbiter.sv - self-checking bench for rnn_mem_arbiter
//
// Reference model works from a per-cycle history of accepted grants:
// round-robin pointer, lock streaks and read returns are derived by
// walking that history.
module tb_rnn_mem_arbiter;

  localparam int         AW        = 17;
  localparam int         DW        = 20;
  localparam int         SW        = 3;
  localparam logic [2:0] WR_SEL    = 3'b101;
  localparam logic [2:0] IDLE_SEL  = 3'b100;
  localparam int         MAX_BURST = 16;
  localparam int         NCYC      = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic          r0_req, r1_req, r0_lock, r1_lock;
  logic [SW-1:0] r0_sel, r1_sel;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          mce;
  logic [SW-1:0] msel;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdata_w;
  logic [DW-1:0] mdata_r;

  always #5 clk = ~clk;

  rnn_mem_arbiter #(
    .AW(AW), .DW(DW), .SW(SW), .WR_SEL(WR_SEL), .IDLE_SEL(IDLE_SEL), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r1_req(r1_req), .r0_lock(r0_lock), .r1_lock(r1_lock),
    .r0_sel(r0_sel), .r1_sel(r1_sel), .r0_addr(r0_addr), .r1_addr(r1_addr),
    .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
    .mce(mce), .msel(msel), .maddr(maddr), .mdata_w(mdata_w), .mdata_r(mdata_r)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Per-cycle history: accepted, winner, winner's lock, other requester busy, reset edge.
  bit h_acc  [NCYC];
  bit h_win  [NCYC];
  bit h_lock [NCYC];
  bit h_oreq [NCYC];
  bit h_rst  [NCYC];
  bit e_rv0  [NCYC+4];
  bit e_rv1  [NCYC+4];

  logic          e_mce   = 1'b0;
  logic [SW-1:0] e_msel  = IDLE_SEL;
  logic [AW-1:0] e_maddr = '0;
  logic [DW-1:0] e_mdw   = '0;

  logic          obs_g0, obs_g1, obs_rv0, obs_rv1;
  logic [DW-1:0] obs_rd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int last_winner();
    for (int k = cyc - 1; k >= 0; k--) begin
      if (h_rst[k]) return 1;
      if (h_acc[k]) return int'(h_win[k]);
    end
    return 1;
  endfunction

  // Consecutive grants to w ending last cycle; an uncontested grant is the
  // first one of the streak.
  function automatic int streak(input int w);
    int n = 0;
    for (int k = cyc - 1; k >= 0; k--) begin
      if (!h_acc[k] || (int'(h_win[k]) != w)) break;
      n++;
      if (!h_oreq[k]) break;
    end
    return n;
  endfunction

  function automatic int model_winner();
    int w;
    if (!r0_req && !r1_req) return -1;
    if (!r1_req) return 0;
    if (!r0_req) return 1;
    if (cyc > 0 && h_acc[cyc-1] && h_lock[cyc-1]) begin
      w = int'(h_win[cyc-1]);
      return (streak(w) < MAX_BURST) ? w : 1 - w;
    end
    return 1 - last_winner();
  endfunction

  task automatic run_cycle();
    int            w;
    logic [SW-1:0] s;
    #3;
    w = model_winner();
    if (!reset) begin
      check("gnt0", r0_gnt, w == 0);
      check("gnt1", r1_gnt, w == 1);
    end
    check("mce", mce, e_mce);
    check("msel", msel, e_msel);
    check("maddr", maddr, e_maddr);
    check("mdata_w", mdata_w, e_mdw);
    check("rvalid0", r0_rvalid, e_rv0[cyc]);
    check("rvalid1", r1_rvalid, e_rv1[cyc]);
    if (e_rv0[cyc]) check("rdata0", r0_rdata, mdata_r);
    if (e_rv1[cyc]) check("rdata1", r1_rdata, mdata_r);
    obs_g0 = r0_gnt; obs_g1 = r1_gnt; obs_rv0 = r0_rvalid; obs_rv1 = r1_rvalid; obs_rd0 = r0_rdata;
    if (reset) begin
      h_rst[cyc] = 1'b1; h_acc[cyc] = 1'b0;
      e_mce = 1'b0; e_msel = IDLE_SEL; e_maddr = '0; e_mdw = '0;
      e_rv0[cyc+1] = 1'b0; e_rv1[cyc+1] = 1'b0;
    end else begin
      h_rst[cyc] = 1'b0;
      h_acc[cyc] = (w >= 0);
      if (w >= 0) begin
        h_win[cyc]  = (w == 1);
        h_lock[cyc] = (w == 1) ? r1_lock : r0_lock;
        h_oreq[cyc] = (w == 1) ? r0_req : r1_req;
        s       = (w == 1) ? r1_sel : r0_sel;
        e_mce   = 1'b1;
        e_msel  = s;
        e_maddr = (w == 1) ? r1_addr : r0_addr;
        e_mdw   = (w == 1) ? r1_wdata : r0_wdata;
        if (s != WR_SEL) begin
          if (w == 0) e_rv0[cyc+2] = 1'b1;
          else        e_rv1[cyc+2] = 1'b1;
        end
      end else begin
        e_mce  = 1'b0;
        e_msel = IDLE_SEL;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= NCYC - 2) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, NCYC - 2);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic set_idle();
    reset = 1'b0;
    r0_req = 1'b0; r1_req = 1'b0; r0_lock = 1'b0; r1_lock = 1'b0;
    r0_sel = 3'b001; r1_sel = 3'b001; r0_addr = '0; r1_addr = '0;
    r0_wdata = '0; r1_wdata = '0;
  endtask

  task automatic reset_cycle();
    set_idle();
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
  endtask

  int wseq[$];
  int run_len[$];
  int run_id[$];
  int r1_cnt;
  int g_cnt;
  bit hold0, hold1;

  initial begin
    set_idle();
    mdata_r = 20'h12345;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single r0 read; reset state is checked by the first cycle.
    r0_req = 1'b1; r0_sel = 3'b001; r0_addr = 17'h00005;
    run_cycle();
    check("tA_gnt0", obs_g0, 1);
    set_idle();
    run_cycle();
    run_cycle();
    check("tA_rvalid0", obs_rv0, 1);
    check("tA_rdata0", obs_rd0, 20'h12345);
    check("tA_rvalid1", obs_rv1, 0);
    run_cycle();

    // Alternating reads without lock, r0 first after reset.
    reset_cycle();
    for (int i = 0; i < 8; i++) begin
      r0_req = 1'b1; r0_sel = 3'b001; r0_addr = 17'(i);
      r1_req = 1'b1; r1_sel = 3'b010; r1_addr = 17'(i + 100);
      mdata_r = 20'($urandom);
      run_cycle();
      check("tB_alt0", obs_g0, (i % 2) == 0);
      check("tB_alt1", obs_g1, (i % 2) == 1);
    end
    set_idle();
    run_cycle();
    run_cycle();

    // r1 write, no read return.
    r1_req = 1'b1; r1_sel = WR_SEL; r1_addr = 17'h1ABCD; r1_wdata = 20'hF0000;
    run_cycle();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      check("tC_no_rvalid1", obs_rv1, 0);
    end

    // Locked r1 burst of 40 against continuous r0.
    reset_cycle();
    r1_cnt = 0;
    for (int i = 0; i < 200 && r1_cnt < 40; i++) begin
      r0_req = 1'b1; r0_lock = 1'b0; r0_sel = 3'b001; r0_addr = 17'(i);
      r1_req = 1'b1; r1_lock = 1'b1; r1_sel = 3'b011; r1_addr = 17'(i);
      run_cycle();
      wseq.push_back(obs_g1 ? 1 : (obs_g0 ? 0 : -1));
      if (obs_g1) r1_cnt++;
    end
    check("tD_r1_total", r1_cnt, 40);
    foreach (wseq[k]) begin
      if (run_id.size() > 0 && run_id[run_id.size()-1] == wseq[k]) begin
        run_len[run_len.size()-1]++;
      end else begin
        run_id.push_back(wseq[k]);
        run_len.push_back(1);
      end
    end
    if (run_len.size() < 4) begin
      check("tD_run_count", run_len.size(), 6);
    end else begin
      check("tD_run1_len", run_len[1], 16);
      check("tD_run1_id", run_id[1], 1);
      check("tD_run2_len", run_len[2], 1);
      check("tD_run2_id", run_id[2], 0);
      check("tD_run3_len", run_len[3], 16);
    end
    set_idle();
    g_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      r1_req = 1'b1; r1_lock = 1'b1; r1_sel = 3'b011; r1_addr = 17'(i);
      run_cycle();
      if (obs_g1) g_cnt++;
    end
    check("tD_uncontested", g_cnt, 40);
    set_idle();
    run_cycle();
    run_cycle();

    // Read accepted, then reset: no return, and r0 wins the first tie.
    r0_req = 1'b1; r0_sel = 3'b001; r0_addr = 17'h00777;
    run_cycle();
    reset_cycle();
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      check("tE_no_rvalid0", obs_rv0, 0);
    end
    r0_req = 1'b1; r1_req = 1'b1;
    run_cycle();
    check("tE_tie_r0", obs_g0, 1);
    set_idle();

    // Idle cycles.
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      check("tF_idle_gnt", {obs_g0, obs_g1}, 0);
    end

    // Randomized traffic; ungranted requests are held stable.
    hold0 = 1'b0; hold1 = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      reset = ($urandom % 150) == 0;
      if (!hold0) begin
        r0_req = ($urandom % 10) < 8; r0_lock = ($urandom % 2) == 0;
        r0_sel = 3'($urandom); r0_addr = 17'($urandom); r0_wdata = 20'($urandom);
      end
      if (!hold1) begin
        r1_req = ($urandom % 10) < 8; r1_lock = ($urandom % 2) == 0;
        r1_sel = 3'($urandom); r1_addr = 17'($urandom); r1_wdata = 20'($urandom);
      end
      mdata_r = 20'($urandom);
      run_cycle();
      hold0 = r0_req && !obs_g0;
      hold1 = r1_req && !obs_g1;
    end
    set_idle();
    run_cycle();
    run_cycle();
    run_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
